// File: rtl/operand_sequencer.sv
// Operand sweep generator for the summator: walks every (r1, r2) pair in row-major
// order, holds each pair for DWELL cycles and strobes o_sample when the sum is valid.
//
//   state   | meaning
//   IDLE    | waiting for i_start after reset
//   RUN     | sweeping pairs, dwell counter active
//   DONE    | sweep complete, o_done held until i_start or i_reset
module operand_sequencer #(
    parameter int REGLENGTH = 3,
    parameter int DWELL     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_pause,
    output logic [REGLENGTH-1:0] o_r1,
    output logic [REGLENGTH-1:0] o_r2,
    output logic                 o_sample,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int                    DCNT_W  = $clog2(DWELL);
    localparam logic [DCNT_W-1:0]     DCNT_TC = DCNT_W'(DWELL - 1);
    localparam logic [REGLENGTH-1:0]  OP_MAX  = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [DCNT_W-1:0]    r_dcnt;
    logic [REGLENGTH-1:0] r_r1;
    logic [REGLENGTH-1:0] r_r2;

    logic w_tc;
    logic w_final;

    // Terminal dwell cycle: the registered sum of the held pair is valid now.
    assign w_tc    = (r_state == ST_RUN) && !i_pause && (r_dcnt == DCNT_TC);
    assign w_final = (r_r1 == OP_MAX) && (r_r2 == OP_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_dcnt  <= '0;
                        r_r1    <= '0;
                        r_r2    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!i_pause) begin
                        if (r_dcnt != DCNT_TC) begin
                            r_dcnt <= r_dcnt + DCNT_W'(1);
                        end else begin
                            r_dcnt <= '0;
                            if (w_final) begin
                                r_state <= ST_DONE;
                                r_r1    <= '0;
                                r_r2    <= '0;
                            end else if (r_r2 == OP_MAX) begin
                                r_r2 <= '0;
                                r_r1 <= r_r1 + REGLENGTH'(1);
                            end else begin
                                r_r2 <= r_r2 + REGLENGTH'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_r1     = r_r1;
    assign o_r2     = r_r2;
    assign o_sample = w_tc;
    assign o_last   = w_tc && w_final;
    assign o_busy   = (r_state == ST_RUN);
    assign o_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: three instances cover (3,2), (3,3) and (1,2)
// operand-width/dwell combinations, with a registered adder on the (3,2) instance.
module tb_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, pause_a;
    logic [2:0] r1_a, r2_a;
    logic       sample_a, last_a, busy_a, done_a;

    logic       rst_b, start_b, pause_b;
    logic [2:0] r1_b, r2_b;
    logic       sample_b, last_b, busy_b, done_b;

    logic       rst_c, start_c, pause_c;
    logic [0:0] r1_c, r2_c;
    logic       sample_c, last_c, busy_c, done_c;

    logic [3:0] sum_a;

    int n_checks = 0;
    int n_fail   = 0;

    operand_sequencer #(.REGLENGTH(3), .DWELL(2)) u_dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_start(start_a), .i_pause(pause_a),
        .o_r1(r1_a), .o_r2(r2_a), .o_sample(sample_a), .o_last(last_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    operand_sequencer #(.REGLENGTH(3), .DWELL(3)) u_dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_start(start_b), .i_pause(pause_b),
        .o_r1(r1_b), .o_r2(r2_b), .o_sample(sample_b), .o_last(last_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    operand_sequencer #(.REGLENGTH(1), .DWELL(2)) u_dut_c (
        .i_clk(clk), .i_reset(rst_c), .i_start(start_c), .i_pause(pause_c),
        .o_r1(r1_c), .o_r2(r2_c), .o_sample(sample_c), .o_last(last_c),
        .o_busy(busy_c), .o_done(done_c)
    );

    // 1-cycle registered summator downstream of instance A
    always_ff @(posedge clk) sum_a <= {1'b0, r1_a} + {1'b0, r2_a};

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pause_a = 1'b0; pause_b = 1'b0; pause_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({r1_a, r2_a, sample_a, last_a, busy_a, done_a} !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got r1=%0d r2=%0d sample=%b last=%b busy=%b done=%b, expected all 0",
                         i, r1_a, r2_a, sample_a, last_a, busy_a, done_a);
            end
        end
    endtask

    // Full sweep on instance A. With from_done=1 the sweep is started from DONE
    // with start held into RUN and pulsed again mid-sweep; both must be ignored.
    task automatic test_full_sweep(input bit from_done);
        int k, nbusy, nsamp, nlast, idx;
        logic [2:0] er1, er2;
        logic exp_s, exp_l;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = from_done;
        k = 0; nbusy = 0; nsamp = 0; nlast = 0;
        while (k < 300) begin
            #1;
            if (!busy_a) break;
            nbusy++;
            idx   = k / 2;
            er1   = 3'(idx / 8);
            er2   = 3'(idx % 8);
            exp_s = (k % 2 == 1);
            exp_l = exp_s && (idx == 63);
            n_checks++;
            if (r1_a !== er1 || r2_a !== er2 || sample_a !== exp_s || last_a !== exp_l || done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_seq(from_done=%0d) cycle %0d: got r1=%0d r2=%0d sample=%b last=%b done=%b, expected r1=%0d r2=%0d sample=%b last=%b done=0",
                         from_done, k, r1_a, r2_a, sample_a, last_a, done_a, er1, er2, exp_s, exp_l);
            end
            if (sample_a) begin
                nsamp++;
                if (last_a) nlast++;
                n_checks++;
                if (sum_a !== ({1'b0, er1} + {1'b0, er2})) begin
                    n_fail++;
                    $display("FAIL sweep_sum cycle %0d: got sum=%0d, expected %0d", k, sum_a, {1'b0, er1} + {1'b0, er2});
                end
            end
            @(negedge clk);
            start_a = from_done && (k + 1 == 37);
            k++;
        end
        start_a = 1'b0;
        n_checks++;
        if (nbusy != 128) begin
            n_fail++;
            $display("FAIL sweep_busy_len: got %0d cycles, expected 128", nbusy);
        end
        n_checks++;
        if (nsamp != 64 || nlast != 1) begin
            n_fail++;
            $display("FAIL sweep_counts: got samples=%0d lasts=%0d, expected 64 and 1", nsamp, nlast);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (done_a !== 1'b1 || busy_a !== 1'b0 || r1_a !== 3'd0 || r2_a !== 3'd0 || sample_a !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_done hold %0d: got done=%b busy=%b r1=%0d r2=%0d sample=%b, expected done=1 busy=0 r1=0 r2=0 sample=0",
                         i, done_a, busy_a, r1_a, r2_a, sample_a);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        #1;
        while (!(r1_a == 3'd4 && r2_a == 3'd1) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL midrun_reach: pair (4,1) not seen, got r1=%0d r2=%0d", r1_a, r2_a);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (busy_a !== 1'b0 || done_a !== 1'b0 || r1_a !== 3'd0 || r2_a !== 3'd0 || sample_a !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_reset cycle %0d: got busy=%b done=%b r1=%0d r2=%0d sample=%b, expected all 0",
                         i, busy_a, done_a, r1_a, r2_a, sample_a);
            end
            @(negedge clk);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b1 || r1_a !== 3'd0 || r2_a !== 3'd0 || sample_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_restart: got busy=%b r1=%0d r2=%0d sample=%b, expected busy=1 r1=0 r2=0 sample=0",
                     busy_a, r1_a, r2_a, sample_a);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (sample_a !== 1'b1 || r1_a !== 3'd0 || r2_a !== 3'd0) begin
            n_fail++;
            $display("FAIL midrun_first_sample: got sample=%b r1=%0d r2=%0d, expected sample=1 r1=0 r2=0",
                     sample_a, r1_a, r2_a);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Instance B, dwell 3: pause for 5 cycles on the sample cycle of pair (2,5) (index 21, cycle 65).
    task automatic test_pause();
        int k, p, eff, idx, nbusy, nsamp;
        logic [2:0] er1, er2;
        logic exp_s, exp_l;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0; p = 0; nbusy = 0; nsamp = 0;
        while (k < 300) begin
            pause_b = (k >= 65 && k <= 69);
            #1;
            if (!busy_b) break;
            nbusy++;
            eff   = k - p;
            idx   = eff / 3;
            er1   = 3'(idx / 8);
            er2   = 3'(idx % 8);
            exp_s = !pause_b && (eff % 3 == 2);
            exp_l = exp_s && (idx == 63);
            n_checks++;
            if (r1_b !== er1 || r2_b !== er2 || sample_b !== exp_s || last_b !== exp_l) begin
                n_fail++;
                $display("FAIL pause_seq cycle %0d: got r1=%0d r2=%0d sample=%b last=%b, expected r1=%0d r2=%0d sample=%b last=%b",
                         k, r1_b, r2_b, sample_b, last_b, er1, er2, exp_s, exp_l);
            end
            if (sample_b) nsamp++;
            if (pause_b) p++;
            @(negedge clk);
            k++;
        end
        pause_b = 1'b0;
        n_checks++;
        if (nbusy != 197 || nsamp != 64) begin
            n_fail++;
            $display("FAIL pause_totals: got busy=%0d samples=%0d, expected busy=197 samples=64", nbusy, nsamp);
        end
        n_checks++;
        if (done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_done: got done=%b, expected 1", done_b);
        end
    endtask

    // Instance C, width 1; start and pause arrive together in IDLE.
    task automatic test_width1();
        int k, idx, nbusy, nsamp;
        logic er1, er2, exp_s, exp_l;
        @(negedge clk);
        start_c = 1'b1;
        pause_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        pause_c = 1'b0;
        k = 0; nbusy = 0; nsamp = 0;
        while (k < 50) begin
            #1;
            if (!busy_c) break;
            nbusy++;
            idx   = k / 2;
            er1   = 1'(idx / 2);
            er2   = 1'(idx % 2);
            exp_s = (k % 2 == 1);
            exp_l = exp_s && (idx == 3);
            n_checks++;
            if (r1_c !== er1 || r2_c !== er2 || sample_c !== exp_s || last_c !== exp_l) begin
                n_fail++;
                $display("FAIL width1_seq cycle %0d: got r1=%0d r2=%0d sample=%b last=%b, expected r1=%0d r2=%0d sample=%b last=%b",
                         k, r1_c, r2_c, sample_c, last_c, er1, er2, exp_s, exp_l);
            end
            if (sample_c) nsamp++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (nbusy != 8 || nsamp != 4 || done_c !== 1'b1) begin
            n_fail++;
            $display("FAIL width1_totals: got busy=%0d samples=%0d done=%b, expected busy=8 samples=4 done=1",
                     nbusy, nsamp, done_c);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep(1'b0);
        test_full_sweep(1'b1);
        test_reset_mid_run();
        test_pause();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Upstream stimulus stage for the summator: on `start` it walks every operand pair (`r1`, `r2`) of width `reglength` in row-major order (`r2` inner, `r1` outer) and holds each pair for a programmable dwell. It flags the cycle in which the downstream registered sum is valid for the current pair. It drives the summator's `r1`/`r2` inputs directly and gives a checker or logger a one-cycle `sample` strobe, replacing hand-written nested stimulus loops.

## Interface
- `reglength`, default 3: operand width in bits; also the summator's `reglength`.
- `dwell`, default 2: cycles each pair is held; legal range 2..15. 2 is the minimum for a 1-cycle-latency summator.
- `clk`  input  1: single clock, all logic on rising edge.
- `reset`  input  1: synchronous, active-high; one clock, synchronous reset active-high, as already decided.
- `start`  input  1: begin a sweep; sampled only in IDLE or DONE.
- `pause`  input  1: freeze the sweep while high, in RUN only.
- `r1`  output  reglength: operand 1 to summator.
- `r2`  output  reglength: operand 2 to summator.
- `sample`  output  1: summator `sum` is valid for the current `r1`/`r2` this cycle.
- `last`  output  1: high together with `sample` on the final pair (all-ones, all-ones).
- `busy`  output  1: high in RUN.
- `done`  output  1: high in DONE; sticky until `start` or `reset`.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE after the final pair's last dwell cycle.
  - DONE → RUN on `start`.
  - Any state → IDLE on `reset`.
- Dwell counter `dcnt` is width ceil(log2(dwell)). It clears on entry to RUN and on each pair advance.
- In RUN with `pause`=0:
  - If `dcnt` < `dwell`-1: `dcnt` increments.
  - If `dcnt` = `dwell`-1: `sample`=1 and the pair advances at that clock edge.
- Pair advance:
  - If `r2` < 2^reglength-1: `r2` increments.
  - Otherwise `r2` goes to 0 and `r1` increments.
  - If `r1` and `r2` are both all-ones: go to DONE, clear `r1`/`r2` to 0, no further advance.
- Pause:
  - `pause`=1 in RUN freezes `dcnt`, `r1`, `r2` and forces `sample`=`last`=0.
  - On release, counting resumes from the frozen `dcnt`.
  - A pause during the sample cycle suppresses that strobe; it re-fires once pause drops.
- Output decoding:
  - `sample` and `last` are combinational from state, `dcnt`, `pause`, `r1`, `r2`.
  - `busy` and `done` decode the state.
- Start handling:
  - `start` in RUN is ignored. There is no restart mid-sweep; use `reset`.
  - `start` held high in DONE starts a new sweep at the next edge. `done` falls as `busy` rises.
- Sweep totals: 2^(2·reglength) `sample` pulses per sweep, exactly one with `last`=1. With `pause` low the run lasts 2^(2·reglength)·`dwell` cycles.
- No arithmetic overflow: `r1`/`r2` wrap only via the explicit advance rule above.

## Timing
- Reset values (at the edge with `reset`=1): state IDLE, `r1`=0, `r2`=0, `dcnt`=0, `sample`=0, `last`=0, `busy`=0, `done`=0.
- `reset` overrides `start`/`pause` on the same edge. A reset mid-RUN returns to IDLE with no DONE pulse.
- Sweep start: with `start` high at edge E0, `busy`=1 and `r1`=`r2`=0 from E0.
- First `sample`: in the cycle after edge E0+(`dwell`-1). Pair (0,0) was presented at E0, so the summator registered it at E0+1, and `sum` is settled by the sample cycle.
- Each pair is stable for exactly `dwell` cycles absent pause. `sample` is high in the last of them.
- End of sweep: the edge that consumes the final sample cycle sets `done`=1, `busy`=0, `r1`=`r2`=0.
- Simultaneous events:
  - `pause`=1 and `start`=1 in IDLE: start is taken; pause is evaluated from the next cycle.
  - `pause` rising on the final sample cycle delays DONE until release.

## Test plan
- Reset then idle (`reglength`=3, `dwell`=2, `start`=0 for 10 cycles) → all outputs 0 throughout.
- Full sweep (`reglength`=3, `dwell`=2, one-cycle `start`):
  - `busy` high for exactly 128 cycles.
  - 64 `sample` pulses in order (0,0),(0,1)…(0,7),(1,0)…(7,7).
  - `last` only with (7,7); `done`=1 on the next cycle, staying 1.
- Summator check: connect a 1-cycle registered adder; at every `sample` assert `sum`=`r1`+`r2`, e.g. 7+7 → 14 at the final pulse.
- Pause (`dwell`=3):
  - Assert `pause` for 5 cycles during the sample cycle of pair (2,5).
  - Required: no `sample` while paused; pair (2,5) is held; a single `sample` for (2,5) on the first unpaused cycle; total pulses still 64.
- Reset mid-run: assert `reset` one cycle while `r1`=4, `r2`=1 → next cycle IDLE, `r1`=`r2`=0, `busy`=`done`=0. A later `start` restarts at (0,0).
- Start handling:
  - `start` pulsed again in RUN → ignored; sequence unchanged.
  - `start` in DONE → `done` drops, `busy` rises, the new sweep begins at (0,0).
- Width corner (`reglength`=1, `dwell`=2) → 4 samples (0,0),(0,1),(1,0),(1,1); `busy` lasts 8 cycles.
